// File: rtl/dircc_avalon_st_packet_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dircc_avalon_st_packet_arbiter
// Description : Round-robin, packet-locked Avalon-ST merger. Sources compete
//               with SOP beats in IDLE; the winner owns the output until its
//               EOP beat is accepted. Stray non-SOP beats in IDLE are drained
//               and flagged, and packets of unexpected length are flagged.
// Revision    : 1.0 - initial release
// ============================================================================
module dircc_avalon_st_packet_arbiter #(
    parameter int NUM_INPUTS   = 4,
    parameter int PACKET_WORDS = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_INPUTS*32-1:0]  in_data,
    input  logic [NUM_INPUTS-1:0]     in_valid,
    input  logic [NUM_INPUTS-1:0]     in_sop,
    input  logic [NUM_INPUTS-1:0]     in_eop,
    input  logic [NUM_INPUTS*2-1:0]   in_empty,
    output logic [NUM_INPUTS-1:0]     in_ready,
    output logic [31:0]               out_data,
    output logic                      out_valid,
    output logic                      out_sop,
    output logic                      out_eop,
    output logic [1:0]                out_empty,
    input  logic                      out_ready,
    output logic [NUM_INPUTS-1:0]     grant,
    output logic                      busy,
    output logic                      length_error,
    output logic                      drop_error
);

    localparam int         c_idx_w       = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam logic [4:0] c_pkt_words   = 5'(PACKET_WORDS);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_LOCKED = 1'b1
    } state_t;

    state_t                r_state;
    logic [NUM_INPUTS-1:0] r_grant;
    logic [c_idx_w-1:0]    r_grant_idx;
    logic [c_idx_w-1:0]    r_last_grant;
    logic [3:0]            r_count;
    logic                  r_len_flagged;   // length error already reported for this packet
    logic                  r_length_error;
    logic                  r_drop_error;

    logic [NUM_INPUTS-1:0] w_request;
    logic [NUM_INPUTS-1:0] w_stray;
    logic                  w_any_request;
    logic [c_idx_w-1:0]    w_sel_idx;
    logic [31:0]           w_src_data;
    logic                  w_src_valid;
    logic                  w_src_sop;
    logic                  w_src_eop;
    logic [1:0]            w_src_empty;
    logic                  w_transfer;
    logic [4:0]            w_count_next;

    assign w_request    = in_valid & in_sop;
    assign w_stray      = in_valid & ~in_sop;
    assign w_transfer   = out_valid & out_ready;
    assign w_count_next = {1'b0, r_count} + 5'd1;

    // Round-robin pick: first requester at or after the input following the last owner
    always_comb begin
        logic [c_idx_w-1:0] idx;
        w_any_request = 1'b0;
        w_sel_idx     = '0;
        idx           = '0;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            idx = c_idx_w'((int'(r_last_grant) + 1 + k) % NUM_INPUTS);
            if (!w_any_request && w_request[idx]) begin
                w_any_request = 1'b1;
                w_sel_idx     = idx;
            end
        end
    end

    // Select the currently granted source's stream signals
    always_comb begin
        w_src_data  = '0;
        w_src_valid = 1'b0;
        w_src_sop   = 1'b0;
        w_src_eop   = 1'b0;
        w_src_empty = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (r_grant_idx == c_idx_w'(i)) begin
                w_src_data  = in_data[i*32 +: 32];
                w_src_valid = in_valid[i];
                w_src_sop   = in_sop[i];
                w_src_eop   = in_eop[i];
                w_src_empty = in_empty[i*2 +: 2];
            end
        end
    end

    // Output stream and per-source ready; everything held quiet during reset
    always_comb begin
        out_valid = 1'b0;
        out_data  = '0;
        out_sop   = 1'b0;
        out_eop   = 1'b0;
        out_empty = '0;
        in_ready  = '0;
        if (!reset) begin
            if (r_state == S_LOCKED) begin
                out_valid = w_src_valid;
                out_data  = w_src_data;
                out_sop   = w_src_sop;
                out_eop   = w_src_eop;
                out_empty = w_src_empty;
                in_ready  = r_grant & {NUM_INPUTS{out_ready}};
            end else begin
                // Non-SOP beats arriving while idle are accepted and discarded
                in_ready  = w_stray;
            end
        end
    end

    // Arbitration/lock state machine with word counting and error pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_grant        <= '0;
            r_grant_idx    <= '0;
            r_last_grant   <= c_idx_w'(NUM_INPUTS - 1);
            r_count        <= '0;
            r_len_flagged  <= 1'b0;
            r_length_error <= 1'b0;
            r_drop_error   <= 1'b0;
        end else begin
            r_length_error <= 1'b0;
            r_drop_error   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_drop_error <= |w_stray;
                    if (w_any_request) begin
                        r_state       <= S_LOCKED;
                        r_grant_idx   <= w_sel_idx;
                        r_grant       <= NUM_INPUTS'(1) << w_sel_idx;
                        r_count       <= '0;
                        r_len_flagged <= 1'b0;
                    end
                end
                S_LOCKED: begin
                    if (w_transfer) begin
                        if (out_eop) begin
                            r_state      <= S_IDLE;
                            r_last_grant <= r_grant_idx;
                            r_grant      <= '0;
                            r_count      <= '0;
                            if (!r_len_flagged && (w_count_next != c_pkt_words)) begin
                                r_length_error <= 1'b1;
                            end
                        end else begin
                            if (r_count != 4'hF) begin
                                r_count <= r_count + 4'd1;
                            end
                            // Packet ran past its expected length: report once, keep forwarding
                            if (!r_len_flagged && (w_count_next == c_pkt_words)) begin
                                r_length_error <= 1'b1;
                                r_len_flagged  <= 1'b1;
                            end
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign grant        = r_grant;
    assign busy         = (r_state == S_LOCKED);
    assign length_error = r_length_error;
    assign drop_error   = r_drop_error;

endmodule
`default_nettype wire

// File: tb/tb_dircc_avalon_st_packet_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dircc_avalon_st_packet_arbiter
// Description : Self-checking bench: cycle-level vector table followed by
//               packet-level scenarios driven by simple Avalon-ST sources.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dircc_avalon_st_packet_arbiter;

    localparam int N  = 4;
    localparam int PW = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic [N*32-1:0]   in_data;
    logic [N-1:0]      in_valid, in_sop, in_eop, in_ready;
    logic [N*2-1:0]    in_empty;
    logic [31:0]       out_data;
    logic              out_valid, out_sop, out_eop, out_ready;
    logic [1:0]        out_empty;
    logic [N-1:0]      grant;
    logic              busy, length_error, drop_error;

    dircc_avalon_st_packet_arbiter #(.NUM_INPUTS(N), .PACKET_WORDS(PW)) dut (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop),
        .in_empty(in_empty), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop),
        .out_empty(out_empty), .out_ready(out_ready),
        .grant(grant), .busy(busy), .length_error(length_error), .drop_error(drop_error)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    // Source models
    int s_pkts[N], s_beat[N], s_len[N], s_pktno[N], s_stall_at[N], s_stall[N];
    logic [N-1:0] stalled;

    // Output monitor
    logic [31:0]  xq[$];
    int           xcyc[$];
    logic [N-1:0] glog[$];
    logic [31:0]  exp_q[$];
    logic [N-1:0] last_g;
    int len_cnt, drop_cnt, len_cyc, stall_cnt, cyc;
    logic [N-1:0] snap_rdy, snap_grant;
    logic         snap_ov, snap_busy;

    function automatic logic [31:0] beat_data(input int i, input int p, input int b);
        return (32'(i) << 24) | (32'(p) << 16) | 32'(b);
    endfunction

    task automatic drive_sources();
        for (int i = 0; i < N; i++) begin
            stalled[i]          = (s_pkts[i] > 0) && (s_beat[i] == s_stall_at[i]) && (s_stall[i] > 0);
            in_valid[i]         = (s_pkts[i] > 0) && !stalled[i];
            in_sop[i]           = (s_beat[i] == 0);
            in_eop[i]           = (s_beat[i] == s_len[i] - 1);
            in_data[i*32 +: 32] = beat_data(i, s_pktno[i], s_beat[i]);
            in_empty[i*2 +: 2]  = in_eop[i] ? 2'(i) : 2'b00;
        end
    endtask

    task automatic clear_mon();
        xq.delete(); xcyc.delete(); glog.delete();
        last_g = '0; len_cnt = 0; drop_cnt = 0; len_cyc = -1; stall_cnt = 0;
    endtask

    // One clock: drive, sample after settling, then advance sources on accepted beats
    task automatic cycle(input logic rst);
        logic [N-1:0] acc;
        reset = rst;
        drive_sources();
        #1;
        snap_ov = out_valid; snap_rdy = in_ready; snap_grant = grant; snap_busy = busy;
        if (out_valid && out_ready) begin xq.push_back(out_data); xcyc.push_back(cyc); end
        if (grant != last_g && grant != '0) glog.push_back(grant);
        last_g = grant;
        if (length_error) begin len_cnt++; len_cyc = cyc; end
        if (drop_error) drop_cnt++;
        if (grant != '0 && !out_valid) stall_cnt++;
        acc = in_ready & in_valid;
        @(posedge clk);
        for (int i = 0; i < N; i++) begin
            if (acc[i]) begin
                if (s_beat[i] == s_len[i] - 1) begin
                    s_beat[i] = 0; s_pkts[i]--; s_pktno[i]++;
                end else begin
                    s_beat[i]++;
                end
            end else if (stalled[i]) begin
                s_stall[i]--;
            end
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic reset_scn();
        for (int i = 0; i < N; i++) begin
            s_pkts[i] = 0; s_beat[i] = 0; s_len[i] = PW; s_pktno[i] = 0;
            s_stall_at[i] = -1; s_stall[i] = 0;
        end
        cycle(1'b1);
        cycle(1'b1);
        clear_mon();
    endtask

    function automatic bit sources_done();
        for (int i = 0; i < N; i++) if (s_pkts[i] > 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic run_done(input string name);
        int k = 0;
        while (k < 300 && !(sources_done() && !busy)) begin
            cycle(1'b0);
            k++;
        end
        check({name, "_timeout"}, 32'(k < 300), 32'd1);
        cycle(1'b0);
        cycle(1'b0);
    endtask

    task automatic check_stream(input string name);
        check({name, "_beats"}, 32'(xq.size()), 32'(exp_q.size()));
        for (int k = 0; k < xq.size() && k < exp_q.size(); k++)
            check($sformatf("%s_beat%0d", name, k), xq[k], exp_q[k]);
    endtask

    typedef struct {
        logic        rst;
        logic [3:0]  v, s, e;
        logic        ordy;
        logic [3:0]  x_rdy;
        logic        x_ov;
        logic [31:0] x_data;
        logic [1:0]  x_emp;
        logic [3:0]  x_g;
        logic        x_busy, x_len, x_drop;
    } vec_t;

    vec_t tbl[11];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; out_ready = 1'b1;
        in_valid = '0; in_sop = '0; in_eop = '0; in_data = '0; in_empty = '0;
        cyc = 0;
        @(negedge clk);
        reset_scn();

        // ---------------- cycle-level vector table ----------------
        //             rst   v        s        e        ordy  x_rdy    ov    data          emp   g        busy  len   drop
        tbl[0]  = '{1'b1, 4'b1111, 4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b0, 32'h0,        2'd0, 4'b0000, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 4'b1000, 4'b0000, 4'b0000, 1'b1, 4'b1000, 1'b0, 32'h0,        2'd0, 4'b0000, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 32'h0,        2'd0, 4'b0000, 1'b0, 1'b0, 1'b1};
        tbl[3]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 32'h0,        2'd0, 4'b0000, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 4'b0010, 4'b0010, 4'b0000, 1'b1, 4'b0000, 1'b0, 32'h0,        2'd0, 4'b0000, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 4'b0010, 4'b0010, 4'b0000, 1'b1, 4'b0010, 1'b1, 32'h22222222, 2'd1, 4'b0010, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 4'b0011, 4'b0011, 4'b0000, 1'b0, 4'b0000, 1'b1, 32'h22222222, 2'd1, 4'b0010, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 4'b0011, 4'b0001, 4'b0010, 1'b1, 4'b0010, 1'b1, 32'h22222222, 2'd1, 4'b0010, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 4'b0001, 4'b0001, 4'b0000, 1'b1, 4'b0000, 1'b0, 32'h0,        2'd0, 4'b0000, 1'b0, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 4'b0001, 4'b0001, 4'b0001, 1'b1, 4'b0001, 1'b1, 32'h11111111, 2'd0, 4'b0001, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 32'h0,        2'd0, 4'b0000, 1'b0, 1'b1, 1'b0};

        in_data  = {32'hDEADBEEF, 32'h33333333, 32'h22222222, 32'h11111111};
        in_empty = 8'b11_10_01_00;
        for (int r = 0; r < 11; r++) begin
            reset = tbl[r].rst; in_valid = tbl[r].v; in_sop = tbl[r].s;
            in_eop = tbl[r].e; out_ready = tbl[r].ordy;
            #1;
            check($sformatf("vec%0d_in_ready", r), 32'(in_ready), 32'(tbl[r].x_rdy));
            check($sformatf("vec%0d_out_valid", r), 32'(out_valid), 32'(tbl[r].x_ov));
            if (tbl[r].x_ov) begin
                check($sformatf("vec%0d_out_data", r), out_data, tbl[r].x_data);
                check($sformatf("vec%0d_out_empty", r), 32'(out_empty), 32'(tbl[r].x_emp));
            end
            check($sformatf("vec%0d_grant", r), 32'(grant), 32'(tbl[r].x_g));
            check($sformatf("vec%0d_busy", r), 32'(busy), 32'(tbl[r].x_busy));
            check($sformatf("vec%0d_length_error", r), 32'(length_error), 32'(tbl[r].x_len));
            check($sformatf("vec%0d_drop_error", r), 32'(drop_error), 32'(tbl[r].x_drop));
            @(posedge clk);
            @(negedge clk);
        end
        out_ready = 1'b1;

        // ---------------- inputs 0 and 2 together ----------------
        reset_scn();
        s_pkts[0] = 1; s_pkts[2] = 1;
        run_done("r034");
        exp_q.delete();
        for (int b = 0; b < PW; b++) exp_q.push_back(beat_data(0, 0, b));
        for (int b = 0; b < PW; b++) exp_q.push_back(beat_data(2, 0, b));
        check_stream("r034");
        check("r034_grants", 32'(glog.size()), 32'd2);
        if (glog.size() == 2) begin
            check("r034_grant0", 32'(glog[0]), 32'b0001);
            check("r034_grant1", 32'(glog[1]), 32'b0100);
        end
        if (xcyc.size() == 2*PW) check("r034_gap", 32'(xcyc[PW] - xcyc[PW-1]), 32'd2);
        check("r034_len_err", 32'(len_cnt), 32'd0);

        // ---------------- all four inputs, two packets each ----------------
        reset_scn();
        for (int i = 0; i < N; i++) s_pkts[i] = 2;
        run_done("r035");
        exp_q.delete();
        for (int p = 0; p < 2; p++)
            for (int i = 0; i < N; i++)
                for (int b = 0; b < PW; b++) exp_q.push_back(beat_data(i, p, b));
        check_stream("r035");
        check("r035_grants", 32'(glog.size()), 32'd8);
        for (int k = 0; k < glog.size() && k < 8; k++)
            check($sformatf("r035_grant%0d", k), 32'(glog[k]), 32'(1 << (k % N)));
        check("r035_stalls", 32'(stall_cnt), 32'd0);

        // ---------------- granted source stalls mid-packet ----------------
        reset_scn();
        s_pkts[1] = 1; s_stall_at[1] = 3; s_stall[1] = 5;
        s_pkts[2] = 1;
        run_done("r036");
        exp_q.delete();
        for (int b = 0; b < PW; b++) exp_q.push_back(beat_data(1, 0, b));
        for (int b = 0; b < PW; b++) exp_q.push_back(beat_data(2, 0, b));
        check_stream("r036");
        check("r036_idle_while_locked", 32'(stall_cnt), 32'd5);
        check("r036_grants", 32'(glog.size()), 32'd2);
        if (glog.size() == 2) begin
            check("r036_grant0", 32'(glog[0]), 32'b0010);
            check("r036_grant1", 32'(glog[1]), 32'b0100);
        end

        // ---------------- short packet ----------------
        reset_scn();
        s_pkts[1] = 1; s_len[1] = 6;
        run_done("r037");
        exp_q.delete();
        for (int b = 0; b < 6; b++) exp_q.push_back(beat_data(1, 0, b));
        check_stream("r037");
        check("r037_len_pulses", 32'(len_cnt), 32'd1);
        if (xcyc.size() == 6) check("r037_len_timing", 32'(len_cyc - xcyc[5]), 32'd1);

        // ---------------- long packet: one pulse after word PW ----------------
        reset_scn();
        s_pkts[2] = 1; s_len[2] = 10;
        run_done("long");
        exp_q.delete();
        for (int b = 0; b < 10; b++) exp_q.push_back(beat_data(2, 0, b));
        check_stream("long");
        check("long_len_pulses", 32'(len_cnt), 32'd1);
        if (xcyc.size() == 10) check("long_len_timing", 32'(len_cyc - xcyc[PW-1]), 32'd1);

        // ---------------- stray beat while idle ----------------
        reset_scn();
        reset = 1'b0;
        in_valid = 4'b1000; in_sop = '0; in_eop = '0;
        in_data  = {32'hDEADBEEF, 96'h0};
        #1;
        check("r038_ready", 32'(in_ready), 32'b1000);
        check("r038_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk); @(negedge clk);
        in_valid = '0;
        #1;
        check("r038_drop_pulse", 32'(drop_error), 32'd1);
        check("r038_out_valid_after", 32'(out_valid), 32'd0);
        @(posedge clk); @(negedge clk);
        #1;
        check("r038_drop_single", 32'(drop_error), 32'd0);
        @(negedge clk);

        // ---------------- reset in the middle of a packet ----------------
        reset_scn();
        s_pkts[1] = 1;
        for (int k = 0; k < 30 && xq.size() < 4; k++) cycle(1'b0);
        check("r039_beats_before", 32'(xq.size()), 32'd4);
        cycle(1'b1);
        check("r039_rst_out_valid", 32'(snap_ov), 32'd0);
        check("r039_rst_ready", 32'(snap_rdy), 32'd0);
        cycle(1'b0);
        check("r039_grant", 32'(snap_grant), 32'd0);
        check("r039_busy", 32'(snap_busy), 32'd0);
        check("r039_out_valid", 32'(snap_ov), 32'd0);
        check("r039_stray_ready", 32'(snap_rdy), 32'b0010);
        for (int k = 0; k < 30 && s_pkts[1] > 0; k++) cycle(1'b0);
        glog.delete();
        s_pkts[0] = 1; s_pkts[1] = 1;
        run_done("r039");
        check("r039_grants", 32'(glog.size()), 32'd2);
        if (glog.size() > 0) check("r039_first_grant", 32'(glog[0]), 32'b0001);
        check("r039_drops", 32'(drop_cnt), 32'd4);
        check("r039_len_err", 32'(len_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dircc_avalon_st_packet_arbiter.md
DIRCC_AVALON_ST_PACKET_ARBITER -- requirements
Module: dircc_avalon_st_packet_arbiter

Interface
REQ-001 Parameter NUM_INPUTS, 4, number of Avalon-ST packet sources (2..8).
REQ-002 Parameter PACKET_WORDS, 8, expected beats per DiRCC packet.
REQ-003 clk  in  1  single clock; all logic rising-edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 in_data  in  NUM_INPUTS*32  per-source beat data; source i at bits [32i+31:32i].
REQ-006 in_valid, in_sop, in_eop  in  NUM_INPUTS each  per-source Avalon-ST qualifiers.
REQ-007 in_empty  in  NUM_INPUTS*2  per-source empty field.
REQ-008 in_ready  out  NUM_INPUTS  per-source ready, ready latency 0.
REQ-009 out_data  out  32  merged stream data to the packet receiver.
REQ-010 out_valid, out_sop, out_eop  out  1 each  merged stream qualifiers.
REQ-011 out_empty  out  2  merged stream empty.
REQ-012 out_ready  in  1  sink ready, ready latency 0.
REQ-013 grant  out  NUM_INPUTS  one-hot current owner; all-zero when idle.
REQ-014 busy  out  1  high while a packet is locked.
REQ-015 length_error  out  1  one-cycle pulse, packet length != PACKET_WORDS.
REQ-016 drop_error  out  1  one-cycle pulse, stray non-SOP beat discarded.

Function
REQ-017 FSM states: IDLE, LOCKED.
REQ-018 Request = in_valid[i] && in_sop[i]; requests evaluated only in IDLE.
REQ-019 IDLE with >=1 request: select by round-robin, search from (last_grant+1) mod NUM_INPUTS upward; register grant, go to LOCKED next cycle (1-cycle arbitration latency).
REQ-020 IDLE: out_valid=0, no beat forwarded in the selection cycle.
REQ-021 LOCKED: out_data/sop/eop/empty/valid = granted source's inputs combinationally; in_ready[g]=out_ready; all other in_ready=0 (except REQ-025).
REQ-022 Transfer = out_valid && out_ready; word counter (4 bits, saturating at 15) increments per transfer, cleared on entry to LOCKED.
REQ-023 Transfer with out_eop: next state IDLE, last_grant <= g, grant <= 0, counter cleared.
REQ-024 Granted source deasserting in_valid mid-packet: stay LOCKED indefinitely; no timeout, no re-arbitration.
REQ-025 IDLE: any source with in_valid=1, in_sop=0 gets in_ready=1 that cycle; beat discarded; drop_error pulses next cycle (single pulse even if several drop together).
REQ-026 EOP transfer with counter+1 != PACKET_WORDS: length_error pulses next cycle; packet still forwarded intact.
REQ-027 Counter reaching PACKET_WORDS without EOP: length_error pulses once next cycle; forwarding continues until EOP; no further pulse for that packet.
REQ-028 SOP seen on granted source mid-packet: forwarded as ordinary data; no state change.
REQ-029 Single requester: granted regardless of last_grant; back-to-back packets from one source separated by exactly one idle cycle.
REQ-030 busy == (state == LOCKED); grant one-hot whenever busy.

Reset
REQ-031 reset high at a clock edge: state IDLE, grant 0, busy 0, counter 0, length_error 0, drop_error 0, last_grant = NUM_INPUTS-1 (input 0 highest first priority).
REQ-032 Outputs out_valid and all in_ready are 0 while reset high.
REQ-033 Reset mid-packet: packet abandoned, no error pulse; remaining beats of that source treated as stray (REQ-025) after reset.

Verification
REQ-034 After reset, inputs 0 and 2 request simultaneously, 8-beat packets -> input 0 packet fully on out, one idle cycle, then input 2 packet; grant 0001 then 0100.
REQ-035 All 4 inputs request continuously, out_ready=1 -> grant order 0,1,2,3,0; each 8-beat packet contiguous and unmixed.
REQ-036 Granted input drops in_valid for 5 cycles after beat 3 -> out_valid low 5 cycles, grant unchanged, other requests ignored, packet completes intact.
REQ-037 Input 1 sends 6-beat packet (EOP on beat 6) -> all 6 beats forwarded, length_error single pulse one cycle after EOP transfer.
REQ-038 Input 3 presents valid, sop=0 in IDLE with data 0xDEADBEEF -> in_ready[3]=1, out_valid stays 0, drop_error pulses once.
REQ-039 Assert reset after beat 4 of a granted packet -> next cycle grant=0, busy=0, out_valid=0; following request from input 0 granted first.
